// File: rtl/ama_riscv_dmem_arbiter.sv
// ama_riscv_dmem_arbiter
// Shares one single-port data memory between the RISC-V core and a debug port.
// At most one requester is granted per cycle. Round-robin resolves contention.
// The grant, the enables and the write lanes are combinational in the grant
// cycle. Read data comes back one cycle later.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   core_req_*            core request: byte address, funct3 width, store data
//   core_rsp_*            core response: raw DMEM word plus the offset and width
//                         of the load, so the core can extract and extend it
//   core_misaligned       previous granted core access was misaligned
//   dbg_req_* / dbg_rsp_* debug word access (address bits [1:0] ignored)
//   dmem_*                memory port; dmem_rdata is valid the cycle after dmem_en
module ama_riscv_dmem_arbiter #(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_req_valid,
    output logic               core_req_ready,
    input  logic               core_req_we,
    input  logic [31:0]        core_req_addr,
    input  logic [2:0]         core_req_width,
    input  logic [31:0]        core_req_wdata,
    output logic               core_rsp_valid,
    output logic [31:0]        core_rsp_data,
    output logic [1:0]         core_rsp_offset,
    output logic [2:0]         core_rsp_width,
    output logic               core_misaligned,
    input  logic               dbg_req_valid,
    output logic               dbg_req_ready,
    input  logic               dbg_req_we,
    input  logic [31:0]        dbg_req_addr,
    input  logic [31:0]        dbg_req_wdata,
    output logic               dbg_rsp_valid,
    output logic [31:0]        dbg_rsp_data,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata
);

    // The access is misaligned when it does not fit inside one word.
    // A width code of 11 is not a legal size.
    function automatic logic access_misaligned(input logic [2:0] width, input logic [1:0] offset);
        logic mis;
        case (width[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = (offset == 2'd3);
            2'b10:   mis = (offset != 2'd0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] width, input logic [1:0] offset);
        logic [3:0] mask;
        case (width[1:0])
            2'b00:   mask = 4'b0001 << offset;
            2'b01:   mask = 4'b0011 << offset;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // The value is replicated across all lanes, so the byte enables alone
    // pick where it lands in the word.
    function automatic logic [31:0] store_data(input logic [2:0] width, input logic [31:0] wdata);
        logic [31:0] data;
        case (width[1:0])
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    logic       last_grant_r;      // 0: core was granted last, 1: debug
    logic       core_rsp_valid_r;
    logic       core_mis_r;
    logic       dbg_rsp_valid_r;
    logic [1:0] core_offset_r;
    logic [2:0] core_width_r;

    logic       grant_core_s;
    logic       grant_dbg_s;
    logic       core_mis_s;

    logic       unused_addr_bits_s;
    assign unused_addr_bits_s = ^{dbg_req_addr[1:0], dbg_req_addr[31:DMEM_AW+2],
                                  core_req_addr[31:DMEM_AW+2]};

    // Grant: a sole requester wins. On contention the requester that was not
    // granted last wins. Nothing is granted while reset is held.
    always_comb begin
        grant_core_s = 1'b0;
        grant_dbg_s  = 1'b0;
        if (rst) begin
            grant_core_s = 1'b0;
            grant_dbg_s  = 1'b0;
        end else if (core_req_valid && dbg_req_valid) begin
            grant_core_s = last_grant_r;
            grant_dbg_s  = ~last_grant_r;
        end else begin
            grant_core_s = core_req_valid;
            grant_dbg_s  = dbg_req_valid;
        end
    end

    // Memory drive for the granted request. A misaligned core access is
    // acknowledged but never reaches the memory.
    always_comb begin
        core_mis_s     = access_misaligned(core_req_width, core_req_addr[1:0]);
        core_req_ready = grant_core_s;
        dbg_req_ready  = grant_dbg_s;
        dmem_en        = 1'b0;
        dmem_we        = 4'b0000;
        dmem_addr      = core_req_addr[DMEM_AW+1:2];
        dmem_wdata     = store_data(core_req_width, core_req_wdata);
        if (grant_dbg_s) begin
            dmem_en    = 1'b1;
            dmem_we    = dbg_req_we ? 4'b1111 : 4'b0000;
            dmem_addr  = dbg_req_addr[DMEM_AW+1:2];
            dmem_wdata = dbg_req_wdata;
        end else if (grant_core_s && !core_mis_s) begin
            dmem_en = 1'b1;
            dmem_we = core_req_we ? store_mask(core_req_width, core_req_addr[1:0]) : 4'b0000;
        end else begin
            dmem_en = 1'b0;
            dmem_we = 4'b0000;
        end
    end

    // Response owner, misalignment flag, load metadata and round-robin state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r     <= 1'b1;
            core_rsp_valid_r <= 1'b0;
            core_mis_r       <= 1'b0;
            dbg_rsp_valid_r  <= 1'b0;
            core_offset_r    <= 2'd0;
            core_width_r     <= 3'd0;
        end else begin
            core_rsp_valid_r <= grant_core_s && !core_req_we;
            core_mis_r       <= grant_core_s && core_mis_s;
            dbg_rsp_valid_r  <= grant_dbg_s && !dbg_req_we;
            if (grant_core_s || grant_dbg_s) begin
                last_grant_r <= grant_dbg_s;
            end
            if (grant_core_s && !core_req_we) begin
                core_offset_r <= core_req_addr[1:0];
                core_width_r  <= core_req_width;
            end
        end
    end

    // Response outputs. A misaligned load returns zero instead of memory data.
    always_comb begin
        core_rsp_valid  = core_rsp_valid_r;
        core_misaligned = core_mis_r;
        core_rsp_offset = core_offset_r;
        core_rsp_width  = core_width_r;
        core_rsp_data   = core_mis_r ? 32'h0000_0000 : dmem_rdata;
        dbg_rsp_valid   = dbg_rsp_valid_r;
        dbg_rsp_data    = dmem_rdata;
    end

endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
module tb_ama_riscv_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0;
    logic [31:0] core_req_addr = 32'h0, core_req_wdata = 32'h0;
    logic [2:0]  core_req_width = 3'd0;
    logic        core_rsp_valid, core_misaligned;
    logic [31:0] core_rsp_data;
    logic [1:0]  core_rsp_offset;
    logic [2:0]  core_rsp_width;
    logic        dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_we = 1'b0;
    logic [31:0] dbg_req_addr = 32'h0, dbg_req_wdata = 32'h0;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    ama_riscv_dmem_arbiter #(.DMEM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_width(core_req_width), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_offset(core_rsp_offset), .core_rsp_width(core_rsp_width),
        .core_misaligned(core_misaligned),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_data(dbg_rsp_data),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the memory last, and what response is due.
    int          m_last;      // 0 core, 1 debug
    int          m_pend;      // 0 none, 1 core load, 2 debug load
    int          m_mis;
    int          m_off;
    int          m_wid;

    // Compare process: every falling edge, model vs DUT.
    initial begin
        m_last = 1; m_pend = 0; m_mis = 0; m_off = 0; m_wid = 0;
        forever begin
            int gc, gd, nbytes, off, mis, e_en;
            logic [3:0]  e_we;
            logic [31:0] e_wd, e_ad, b;
            @(negedge clk);
            if (rst) begin
                m_last = 1; m_pend = 0; m_mis = 0; m_off = 0; m_wid = 0;
            end
            gc = 0; gd = 0;
            if (!rst) begin
                if (core_req_valid && (!dbg_req_valid || m_last == 1)) gc = 1;
                else if (dbg_req_valid) gd = 1;
            end
            off    = int'(core_req_addr[1:0]);
            nbytes = 1 << core_req_width[1:0];
            mis    = (core_req_width[1:0] == 2'b11 || off + nbytes > 4) ? 1 : 0;
            e_en   = (gd == 1 || (gc == 1 && mis == 0)) ? 1 : 0;
            e_we   = 4'h0;
            e_wd   = 32'h0;
            e_ad   = 32'h0;
            if (gd == 1) begin
                e_we = dbg_req_we ? 4'hF : 4'h0;
                e_wd = dbg_req_wdata;
                e_ad = (dbg_req_addr >> 2) & 32'h3FFF;
            end else if (gc == 1 && mis == 0) begin
                e_we = core_req_we ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
                b    = core_req_wdata;
                if (nbytes == 1)      e_wd = (b & 32'hFF) * 32'h0101_0101;
                else if (nbytes == 2) e_wd = (b & 32'hFFFF) * 32'h0001_0001;
                else                  e_wd = b;
                e_ad = (core_req_addr >> 2) & 32'h3FFF;
            end
            chk("core_req_ready", 32'(core_req_ready), 32'(gc));
            chk("dbg_req_ready", 32'(dbg_req_ready), 32'(gd));
            chk("dmem_en", 32'(dmem_en), 32'(e_en));
            chk("dmem_we", 32'(dmem_we), 32'(e_we));
            if (e_en == 1) begin
                chk("dmem_addr", 32'(dmem_addr), e_ad);
                chk("dmem_wdata", dmem_wdata, e_wd);
            end
            chk("core_rsp_valid", 32'(core_rsp_valid), 32'(m_pend == 1));
            chk("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(m_pend == 2));
            chk("core_misaligned", 32'(core_misaligned), 32'(m_mis));
            chk("core_rsp_offset", 32'(core_rsp_offset), 32'(m_off));
            chk("core_rsp_width", 32'(core_rsp_width), 32'(m_wid));
            if (m_pend == 1) chk("core_rsp_data", core_rsp_data, (m_mis == 1) ? 32'h0 : dmem_rdata);
            if (m_pend == 2) chk("dbg_rsp_data", dbg_rsp_data, dmem_rdata);
            // state after the coming rising edge
            if (!rst) begin
                m_pend = 0;
                m_mis  = 0;
                if (gc == 1) begin
                    m_last = 0;
                    m_mis  = mis;
                    if (!core_req_we) begin
                        m_pend = 1;
                        m_off  = off;
                        m_wid  = int'(core_req_width);
                    end
                end else if (gd == 1) begin
                    m_last = 1;
                    if (!dbg_req_we) m_pend = 2;
                end
            end
        end
    end

    task automatic step(input logic r,
                        input logic cv, input logic cwe, input logic [31:0] ca,
                        input logic [2:0] cw, input logic [31:0] cd,
                        input logic dv, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dd, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst = r;
        core_req_valid = cv; core_req_we = cwe; core_req_addr = ca;
        core_req_width = cw; core_req_wdata = cd;
        dbg_req_valid = dv; dbg_req_we = dwe; dbg_req_addr = da; dbg_req_wdata = dd;
        dmem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle(input logic r, input logic [31:0] rd);
        step(r, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, rd);
    endtask

    initial begin
        // reset held, both requesting: nothing granted
        idle(1'b1, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("rst_core_ready", 32'(core_req_ready), 32'h0);
        chk("rst_dmem_en", 32'(dmem_en), 32'h0);

        // round-robin under continuous contention: core, dbg, core, dbg
        step(1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("rr1_core_ready", 32'(core_req_ready), 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111);
        chk("rr2_dbg_ready", 32'(dbg_req_ready), 32'h1);
        chk("rr2_core_rsp", 32'(core_rsp_valid), 32'h1);
        chk("rr2_core_data", core_rsp_data, 32'h1111_1111);
        step(1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h2222_2222);
        chk("rr3_core_ready", 32'(core_req_ready), 32'h1);
        chk("rr3_dbg_rsp", 32'(dbg_rsp_valid), 32'h1);
        chk("rr3_dbg_data", dbg_rsp_data, 32'h2222_2222);
        step(1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h3333_3333);
        chk("rr4_dbg_ready", 32'(dbg_req_ready), 32'h1);
        chk("rr4_core_rsp", 32'(core_rsp_valid), 32'h1);
        idle(1'b0, 32'h4444_4444);
        chk("rr5_dbg_rsp", 32'(dbg_rsp_valid), 32'h1);
        chk("rr5_core_rsp", 32'(core_rsp_valid), 32'h0);

        // core SB 0x1003
        step(1'b0, 1'b1, 1'b1, 32'h1003, 3'd0, 32'hAB, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("sb_en", 32'(dmem_en), 32'h1);
        chk("sb_we", 32'(dmem_we), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", 32'(dmem_addr), 32'h400);
        idle(1'b0, 32'h0);
        chk("sb_no_rsp", 32'(core_rsp_valid), 32'h0);

        // core LHU 0x0102
        step(1'b0, 1'b1, 1'b0, 32'h0102, 3'b101, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(1'b0, 32'hBEEF_1234);
        chk("lhu_valid", 32'(core_rsp_valid), 32'h1);
        chk("lhu_data", core_rsp_data, 32'hBEEF_1234);
        chk("lhu_offset", 32'(core_rsp_offset), 32'h2);
        chk("lhu_width", 32'(core_rsp_width), 32'h5);

        // core LW 0x0006 misaligned
        step(1'b0, 1'b1, 1'b0, 32'h0006, 3'b010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("lw_mis_ready", 32'(core_req_ready), 32'h1);
        chk("lw_mis_en", 32'(dmem_en), 32'h0);
        idle(1'b0, 32'h5555_AAAA);
        chk("lw_mis_valid", 32'(core_rsp_valid), 32'h1);
        chk("lw_mis_flag", 32'(core_misaligned), 32'h1);
        chk("lw_mis_data", core_rsp_data, 32'h0);

        // debug SW 0x0013
        step(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b1, 32'h0013, 32'hDEAD_BEEF, 32'h0);
        chk("dsw_we", 32'(dmem_we), 32'hF);
        chk("dsw_addr", 32'(dmem_addr), 32'h4);
        chk("dsw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        idle(1'b0, 32'h0);
        chk("dsw_no_rsp", 32'(dbg_rsp_valid), 32'h0);

        // debug LW interrupted by reset
        step(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0020, 32'h0, 32'h0);
        chk("dlw_ready", 32'(dbg_req_ready), 32'h1);
        idle(1'b1, 32'h1234_5678);
        chk("dlw_rst_rsp", 32'(dbg_rsp_valid), 32'h0);
        idle(1'b0, 32'h1234_5678);
        chk("post_rst_dbg_rsp", 32'(dbg_rsp_valid), 32'h0);
        chk("post_rst_core_rsp", 32'(core_rsp_valid), 32'h0);
        chk("post_rst_en", 32'(dmem_en), 32'h0);
        idle(1'b0, 32'h0);
        chk("post_rst_mis", 32'(core_misaligned), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom & 32'h0001_FFFF, 3'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom & 32'h0001_FFFF, $urandom, $urandom);
        end
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
